// File: rtl/dp_ctrl_pkg.sv
// Shared opcode constants, arbiter state encodings and the idle datapath
// control bundle used by the two-requester datapath arbiter.
package dp_ctrl_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_ADDU  = 8'h05;
    localparam logic [7:0] OP_ADDUI = 8'h50;
    localparam logic [7:0] OP_CMP   = 8'h0B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    typedef struct packed {
        logic [15:0] wEnable;
        logic [15:0] Imm_in;
        logic [7:0]  opcode;
        logic [3:0]  Rdest_sel;
        logic [3:0]  Rsrc_sel;
        logic        Imm_sel;
    } dp_bundle_t;

    // Idle bundle: no register write, NOP, immediate path selected.
    localparam dp_bundle_t DP_BUNDLE_DEFAULT = '{
        wEnable:   16'h0000,
        Imm_in:    16'h0000,
        opcode:    OP_NOP,
        Rdest_sel: 4'h0,
        Rsrc_sel:  4'h0,
        Imm_sel:   1'b1
    };

endpackage

// File: rtl/datapath_arbiter_if.sv
// One datapath control bundle; master drives it, slave consumes it.
interface dp_bundle_if;
    import dp_ctrl_pkg::*;

    dp_bundle_t b;

    modport master (output b);
    modport slave  (input  b);
endinterface

// File: rtl/datapath_arbiter_bundle_mux.sv
// Combinational 2:1 bundle select; falls back to the idle bundle when the
// owner is not actively requesting.
module datapath_bundle_mux
    import dp_ctrl_pkg::*;
(
    input  logic  sel_r0,
    input  logic  sel_r1,
    dp_bundle_if.slave  in_r0,
    dp_bundle_if.slave  in_r1,
    dp_bundle_if.master out_b
);

    always_comb begin
        out_b.b = DP_BUNDLE_DEFAULT;
        if (sel_r0) begin
            out_b.b = in_r0.b;
        end else if (sel_r1) begin
            out_b.b = in_r1.b;
        end
    end

endmodule

// File: rtl/datapath_arbiter.sv
// Two-requester datapath arbiter: round-robin tie break, quantum-limited
// preemption with lock, zero-bubble handover and per-requester flag capture.
//   state   | meaning
//   IDLE    | nobody owns the datapath, idle bundle driven
//   OWN0    | requester 0 owns the datapath
//   OWN1    | requester 1 owns the datapath
module datapath_arbiter
    import dp_ctrl_pkg::*;
#(
    parameter int QUANTUM = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_r0,
    input  logic        lock_r0,
    input  logic [15:0] wEnable_r0,
    input  logic [15:0] Imm_in_r0,
    input  logic [7:0]  opcode_r0,
    input  logic [3:0]  Rdest_sel_r0,
    input  logic [3:0]  Rsrc_sel_r0,
    input  logic        Imm_sel_r0,

    input  logic        req_r1,
    input  logic        lock_r1,
    input  logic [15:0] wEnable_r1,
    input  logic [15:0] Imm_in_r1,
    input  logic [7:0]  opcode_r1,
    input  logic [3:0]  Rdest_sel_r1,
    input  logic [3:0]  Rsrc_sel_r1,
    input  logic        Imm_sel_r1,

    output logic        gnt_r0,
    output logic        gnt_r1,

    output logic [15:0] wEnable,
    output logic [15:0] Imm_in,
    output logic [7:0]  opcode,
    output logic [3:0]  Rdest_sel,
    output logic [3:0]  Rsrc_sel,
    output logic        Imm_sel,

    input  logic [4:0]  Flags_out,
    output logic [4:0]  flags_r0,
    output logic [4:0]  flags_r1
);

    localparam logic [3:0] Q_MAX  = 4'(QUANTUM);
    localparam logic [3:0] Q_LAST = 4'(QUANTUM - 1);

    logic [1:0] state_q,    state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic [4:0] flags_r0_q, flags_r0_d;
    logic [4:0] flags_r1_q, flags_r1_d;

    logic act_r0, act_r1;

    dp_bundle_if r0_if ();
    dp_bundle_if r1_if ();
    dp_bundle_if out_if ();

    assign r0_if.b = '{wEnable: wEnable_r0, Imm_in: Imm_in_r0, opcode: opcode_r0,
                       Rdest_sel: Rdest_sel_r0, Rsrc_sel: Rsrc_sel_r0, Imm_sel: Imm_sel_r0};
    assign r1_if.b = '{wEnable: wEnable_r1, Imm_in: Imm_in_r1, opcode: opcode_r1,
                       Rdest_sel: Rdest_sel_r1, Rsrc_sel: Rsrc_sel_r1, Imm_sel: Imm_sel_r1};

    assign gnt_r0 = (state_q == ST_OWN0);
    assign gnt_r1 = (state_q == ST_OWN1);
    assign act_r0 = gnt_r0 && req_r0;
    assign act_r1 = gnt_r1 && req_r1;

    datapath_bundle_mux u_mux (
        .sel_r0 (act_r0),
        .sel_r1 (act_r1),
        .in_r0  (r0_if),
        .in_r1  (r1_if),
        .out_b  (out_if)
    );

    assign wEnable   = out_if.b.wEnable;
    assign Imm_in    = out_if.b.Imm_in;
    assign opcode    = out_if.b.opcode;
    assign Rdest_sel = out_if.b.Rdest_sel;
    assign Rsrc_sel  = out_if.b.Rsrc_sel;
    assign Imm_sel   = out_if.b.Imm_sel;
    assign flags_r0  = flags_r0_q;
    assign flags_r1  = flags_r1_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_r0 && req_r1) begin
                    state_d = last_gnt_q ? ST_OWN0 : ST_OWN1;
                end else if (req_r0) begin
                    state_d = ST_OWN0;
                end else if (req_r1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!req_r0) begin
                    state_d = req_r1 ? ST_OWN1 : ST_IDLE;
                end else if (req_r1 && !lock_r0 && hold_cnt_q >= Q_LAST) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req_r1) begin
                    state_d = req_r0 ? ST_OWN0 : ST_IDLE;
                end else if (req_r0 && !lock_r1 && hold_cnt_q >= Q_LAST) begin
                    state_d = ST_OWN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any change of owner (including a direct handover) restarts the tenure.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        last_gnt_d = last_gnt_q;
        if (state_d == ST_IDLE || state_d != state_q) begin
            hold_cnt_d = 4'd0;
        end else if (hold_cnt_q < Q_MAX) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end
        if (state_d != state_q && state_d == ST_OWN0) last_gnt_d = 1'b0;
        if (state_d != state_q && state_d == ST_OWN1) last_gnt_d = 1'b1;
    end

    always_comb begin
        flags_r0_d = flags_r0_q;
        flags_r1_d = flags_r1_q;
        if (act_r0 && opcode_r0 != OP_NOP) flags_r0_d = Flags_out;
        if (act_r1 && opcode_r1 != OP_NOP) flags_r1_d = Flags_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= 4'd0;
            last_gnt_q <= 1'b1;
            flags_r0_q <= 5'd0;
            flags_r1_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_gnt_q <= last_gnt_d;
            flags_r0_q <= flags_r0_d;
            flags_r1_q <= flags_r1_d;
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Randomized and directed bench for datapath_arbiter against an owner/tenure
// reference model.
module tb_datapath_arbiter;
    import dp_ctrl_pkg::*;

    localparam int QUANTUM = 8;

    logic clk;
    logic reset;
    logic req_r0, req_r1, lock_r0, lock_r1;
    logic gnt_r0, gnt_r1;
    logic [15:0] wEnable, Imm_in;
    logic [7:0]  opcode;
    logic [3:0]  Rdest_sel, Rsrc_sel;
    logic        Imm_sel;
    logic [4:0]  Flags_out, flags_r0, flags_r1;

    dp_bundle_if bif0 ();
    dp_bundle_if bif1 ();

    int n_checks = 0;
    int n_errors = 0;

    int         m_owner;
    int         m_tenure;
    int         m_last;
    logic [4:0] m_flags [2];

    datapath_arbiter #(.QUANTUM(QUANTUM)) dut (
        .clk(clk), .reset(reset),
        .req_r0(req_r0), .lock_r0(lock_r0),
        .wEnable_r0(bif0.b.wEnable), .Imm_in_r0(bif0.b.Imm_in), .opcode_r0(bif0.b.opcode),
        .Rdest_sel_r0(bif0.b.Rdest_sel), .Rsrc_sel_r0(bif0.b.Rsrc_sel), .Imm_sel_r0(bif0.b.Imm_sel),
        .req_r1(req_r1), .lock_r1(lock_r1),
        .wEnable_r1(bif1.b.wEnable), .Imm_in_r1(bif1.b.Imm_in), .opcode_r1(bif1.b.opcode),
        .Rdest_sel_r1(bif1.b.Rdest_sel), .Rsrc_sel_r1(bif1.b.Rsrc_sel), .Imm_sel_r1(bif1.b.Imm_sel),
        .gnt_r0(gnt_r0), .gnt_r1(gnt_r1),
        .wEnable(wEnable), .Imm_in(Imm_in), .opcode(opcode),
        .Rdest_sel(Rdest_sel), .Rsrc_sel(Rsrc_sel), .Imm_sel(Imm_sel),
        .Flags_out(Flags_out), .flags_r0(flags_r0), .flags_r1(flags_r1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] cmp_flags(input logic [15:0] a, input logic [15:0] b);
        return {a < b, a == b, $signed(a) < $signed(b), 2'b00};
    endfunction

    task automatic set_bundle(input int k, input logic [15:0] we, input logic [15:0] imm,
                              input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                              input logic isel);
        dp_bundle_t v;
        v = '{wEnable: we, Imm_in: imm, opcode: op, Rdest_sel: rd, Rsrc_sel: rs, Imm_sel: isel};
        if (k == 0) bif0.b = v;
        else        bif1.b = v;
    endtask

    // Clock-edge behaviour of the arbiter expressed as owner + tenure length.
    task automatic model_edge();
        int nxt;
        logic rq [2];
        logic lk [2];
        logic [7:0] op [2];
        rq[0] = req_r0; rq[1] = req_r1;
        lk[0] = lock_r0; lk[1] = lock_r1;
        op[0] = bif0.b.opcode; op[1] = bif1.b.opcode;
        if (reset) begin
            m_owner = -1; m_tenure = 0; m_last = 1;
            m_flags[0] = '0; m_flags[1] = '0;
            return;
        end
        if (m_owner >= 0 && rq[m_owner] && op[m_owner] != 8'h00) m_flags[m_owner] = Flags_out;
        if (m_owner < 0) begin
            if (rq[0] && rq[1]) nxt = 1 - m_last;
            else if (rq[0])     nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else begin
            nxt = m_owner;
            if (!rq[m_owner])                                               nxt = rq[1-m_owner] ? 1 - m_owner : -1;
            else if (rq[1-m_owner] && !lk[m_owner] && m_tenure >= QUANTUM) nxt = 1 - m_owner;
        end
        if (nxt < 0) begin
            m_tenure = 0;
        end else if (nxt != m_owner) begin
            m_tenure = 1;
            m_last = nxt;
        end else begin
            m_tenure++;
        end
        m_owner = nxt;
    endtask

    task automatic check_outputs();
        logic [48:0] exp_b;
        logic [48:0] got_b;
        exp_b = {16'h0, 16'h0, 8'h00, 4'h0, 4'h0, 1'b1};
        if (m_owner == 0 && req_r0) exp_b = bif0.b;
        if (m_owner == 1 && req_r1) exp_b = bif1.b;
        got_b = {wEnable, Imm_in, opcode, Rdest_sel, Rsrc_sel, Imm_sel};
        check_val("gnt_r0", 64'(gnt_r0), 64'(m_owner == 0));
        check_val("gnt_r1", 64'(gnt_r1), 64'(m_owner == 1));
        check_val("bundle", 64'(got_b), 64'(exp_b));
        check_val("flags_r0", 64'(flags_r0), 64'(m_flags[0]));
        check_val("flags_r1", 64'(flags_r1), 64'(m_flags[1]));
    endtask

    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt0;
        logic [63:0] r;
        reset = 1'b1;
        req_r0 = 0; req_r1 = 0; lock_r0 = 0; lock_r1 = 0;
        Flags_out = 5'h0;
        set_bundle(0, 16'h0001, 16'h1111, OP_ADDU, 4'd1, 4'd2, 1'b0);
        set_bundle(1, 16'h0002, 16'h2222, OP_ADDUI, 4'd3, 4'd4, 1'b0);
        m_owner = -1; m_tenure = 0; m_last = 1; m_flags[0] = '0; m_flags[1] = '0;
        do_reset();
        step();

        // Simultaneous requests after reset: requester 0 wins, then alternate.
        req_r0 = 1; req_r1 = 1; Flags_out = 5'h0A;
        step();
        check_val("tie_gnt_r0", 64'(gnt_r0), 64'd1);
        check_val("tie_gnt_r1", 64'(gnt_r1), 64'd0);
        cnt0 = 0;
        for (int i = 0; i < 32; i++) begin
            if (gnt_r0) cnt0++;
            step();
        end
        check_val("quantum_share_r0", 64'(cnt0), 64'd16);

        // Lock holds ownership past the quantum.
        do_reset();
        req_r0 = 1; req_r1 = 0;
        step(); step();
        req_r1 = 1; lock_r0 = 1;
        for (int i = 0; i < 20; i++) step();
        check_val("lock_gnt_r0", 64'(gnt_r0), 64'd1);
        lock_r0 = 0;
        step();
        check_val("unlock_gnt_r1", 64'(gnt_r1), 64'd1);
        step();

        // Zero-bubble handover when the owner drops its request.
        do_reset();
        req_r0 = 1; req_r1 = 0;
        step(); step();
        req_r1 = 1; req_r0 = 0;
        #1;
        check_val("drop_wEnable", 64'(wEnable), 64'd0);
        step();
        check_val("handover_gnt_r1", 64'(gnt_r1), 64'd1);
        step();

        // CMP R3,R4 from requester 1 captures flags; a NOP holds them.
        do_reset();
        req_r0 = 0; req_r1 = 1;
        set_bundle(1, 16'h0000, 16'h0000, OP_CMP, 4'd3, 4'd4, 1'b0);
        Flags_out = cmp_flags(16'd2, 16'd10);
        step(); step();
        set_bundle(1, 16'h0000, 16'h0000, OP_NOP, 4'd0, 4'd0, 1'b0);
        Flags_out = 5'b00111;
        step();
        check_val("cmp_flags_r1_bit4", 64'(flags_r1[4]), 64'd1);
        check_val("cmp_flags_r0", 64'(flags_r0), 64'd0);

        // Reset in the middle of OWN1 ownership.
        set_bundle(1, 16'h0020, 16'h0005, OP_ADDU, 4'd5, 4'd6, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("rst_wEnable", 64'(wEnable), 64'd0);
        check_val("rst_opcode", 64'(opcode), 64'd0);
        step();

        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 199) == 0);
            req_r0  = ($urandom_range(0, 3) != 0);
            req_r1  = ($urandom_range(0, 3) != 0);
            lock_r0 = ($urandom_range(0, 4) == 0);
            lock_r1 = ($urandom_range(0, 4) == 0);
            Flags_out = 5'($urandom);
            r = {$urandom, $urandom};
            bif0.b = dp_bundle_t'(r[48:0]);
            if ($urandom_range(0, 3) == 0) bif0.b.opcode = OP_NOP;
            r = {$urandom, $urandom};
            bif1.b = dp_bundle_t'(r[48:0]);
            if ($urandom_range(0, 3) == 0) bif1.b.opcode = OP_NOP;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
